// File: rtl/encoder_8to3_sync.sv
// Clocked 8-to-3 request encoder: captures falling edges on active-low select
// lines and serves them highest-index-first as {A,B,C} under a valid/ack handshake.
module encoder_8to3_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] Y_n,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       valid,
    input  logic       ack,
    output logic [7:0] pending,
    output logic       overrun
);

    // state   | meaning
    // IDLE    | no code presented, valid=0
    // PRESENT | {A,B,C} holds a served request, valid=1
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    logic [7:0] y_q;
    logic [7:0] fall;
    logic [7:0] srv;
    logic [7:0] pending_next;
    logic [2:0] code;

    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        fall = y_q & ~Y_n & {8{en}};
        srv  = 8'h00;
        if (valid && ack) srv[code] = 1'b1;
        pending_next = (pending & ~srv) | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 8'hFF;
            pending <= 8'h00;
            overrun <= 1'b0;
        end else begin
            y_q     <= Y_n;
            pending <= pending_next;
            overrun <= |(fall & pending & ~srv);
        end
    end

    // From IDLE only already-registered requests are launched, so a fresh edge
    // shows up in pending one cycle before valid rises (two-cycle latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            valid <= 1'b0;
            code  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != 8'h00) begin
                        code  <= top_index(pending);
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        if (pending_next != 8'h00) begin
                            code <= top_index(pending_next);
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign {A, B, C} = code;

endmodule

// File: tb/tb_encoder_8to3_sync.sv
// Self-checking bench for encoder_8to3_sync: directed scenarios plus random
// traffic, all compared against a request-list reference model.
module tb_encoder_8to3_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] Y_n = 8'hFF;
    logic       ack = 1'b0;
    logic       A, B, C, valid, overrun;
    logic [7:0] pending;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit       m_req [8];
    bit       m_line[8];
    bit       m_valid;
    int       m_code;
    bit       m_over;

    logic [12:0] obs;
    logic [12:0] exp_v;

    encoder_8to3_sync dut (
        .clk(clk), .rst_n(rst_n), .en(en), .Y_n(Y_n),
        .A(A), .B(B), .C(C), .valid(valid), .ack(ack),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_req[i];
        return v;
    endfunction

    function automatic int highest_req();
        int h;
        h = -1;
        for (int i = 0; i < 8; i++) if (m_req[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_req[i]  = 0;
            m_line[i] = 1;
        end
        m_valid = 0;
        m_code  = 0;
        m_over  = 0;
    endtask

    // One clock edge of the behavioural rules, using the inputs seen at the edge.
    task automatic model_edge(input logic [7:0] y, input logic e, input logic a);
        bit fell, served, had_any;
        int h;
        had_any = (highest_req() >= 0);
        m_over = 0;
        for (int i = 0; i < 8; i++) begin
            fell   = m_line[i] && !y[i] && e;
            served = m_valid && a && (m_code == i);
            if (fell && m_req[i] && !served) m_over = 1;
            if (served) m_req[i] = 0;
            if (fell) m_req[i] = 1;
            m_line[i] = y[i];
        end
        if (!m_valid) begin
            if (had_any) begin
                // requests registered before this edge; pick from the pre-edge set
                m_valid = 1;
            end
        end else if (a) begin
            h = highest_req();
            if (h >= 0) m_code = h;
            else m_valid = 0;
        end
    endtask

    // IDLE launch uses the pre-edge request set, so it is resolved here.
    task automatic step(input logic [7:0] y, input logic e, input logic a);
        bit          was_valid;
        logic [7:0]  pre;
        @(negedge clk);
        Y_n = y; en = e; ack = a;
        was_valid = m_valid;
        pre = m_pend_vec();
        @(posedge clk);
        model_edge(y, e, a);
        if (!was_valid && m_valid) begin
            for (int i = 0; i < 8; i++) if (pre[i]) m_code = i;
        end
        #1;
        obs   = {valid, A, B, C, pending, overrun};
        exp_v = {m_valid, 3'(m_code), m_pend_vec(), m_over};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        obs   = {valid, A, B, C, pending, overrun};
        n_vec++;
        if (obs !== 13'h0) begin
            n_err++;
            $display("FAIL reset_init: got %h exp %h", obs, 13'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // bring code 5 up, then reset mid-PRESENT
        step(8'hDF, 1'b1, 1'b0);
        step(8'hDF, 1'b1, 1'b0);
        n_vec++;
        if ({valid, A, B, C} !== 4'b1101) begin
            n_err++;
            $display("FAIL reset_pre_code5: got %b exp %b", {valid, A, B, C}, 4'b1101);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        obs = {valid, A, B, C, pending, overrun};
        n_vec++;
        if (obs !== 13'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h exp %h", obs, 13'h0);
        end
        Y_n = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(8'hFF, 1'b1, 1'b0);
            n_vec++;
            if (obs !== 13'h0 || obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_quiet%0d: got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_single();
        step(8'hFB, 1'b1, 1'b0);
        n_vec++;
        if (pending !== 8'h04 || valid !== 1'b0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL single_capture: got %h exp %h", obs, exp_v);
        end
        step(8'hFB, 1'b1, 1'b0);
        n_vec++;
        if ({valid, A, B, C} !== 4'b1010 || obs !== exp_v) begin
            n_err++;
            $display("FAIL single_present: got %h exp %h", obs, exp_v);
        end
        step(8'hFB, 1'b1, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || pending !== 8'h00 || obs !== exp_v) begin
            n_err++;
            $display("FAIL single_ack: got %h exp %h", obs, exp_v);
        end
        step(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_priority();
        logic [2:0] want[3] = '{3'd6, 3'd7, 3'd1};
        step(8'hBD, 1'b1, 1'b0);
        step(8'hBD, 1'b1, 1'b0);
        n_vec++;
        if ({valid, A, B, C} !== {1'b1, want[0]} || obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_first: got %h exp %h", obs, exp_v);
        end
        step(8'h3D, 1'b1, 1'b0);
        step(8'h3D, 1'b1, 1'b0);
        n_vec++;
        if ({valid, A, B, C} !== {1'b1, want[0]} || pending !== 8'hC2 || obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_no_preempt: got %h exp %h", obs, exp_v);
        end
        for (int k = 1; k < 3; k++) begin
            step(8'h3D, 1'b1, 1'b1);
            n_vec++;
            if ({valid, A, B, C} !== {1'b1, want[k]} || obs !== exp_v) begin
                n_err++;
                $display("FAIL prio_seq%0d: got %h exp %h", k, obs, exp_v);
            end
        end
        step(8'h3D, 1'b1, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_drain: got %h exp %h", obs, exp_v);
        end
        step(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(8'h00, 1'b1, 1'b1);
        n_vec++;
        if (pending !== 8'hFF || valid !== 1'b0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_capture: got %h exp %h", obs, exp_v);
        end
        for (int k = 7; k >= 0; k--) begin
            step(8'h00, 1'b1, 1'b1);
            n_vec++;
            if ({valid, A, B, C} !== {1'b1, 3'(k)} || obs !== exp_v) begin
                n_err++;
                $display("FAIL b2b_code%0d: got %h exp %h", k, obs, exp_v);
            end
        end
        step(8'h00, 1'b1, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || pending !== 8'h00 || obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_end: got %h exp %h", obs, exp_v);
        end
        step(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        step(8'hF7, 1'b1, 1'b0);
        step(8'hF7, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        step(8'hF7, 1'b1, 1'b0);
        n_vec++;
        if (overrun !== 1'b1 || pending !== 8'h08 || obs !== exp_v) begin
            n_err++;
            $display("FAIL ovr_pulse: got %h exp %h", obs, exp_v);
        end
        step(8'hF7, 1'b1, 1'b0);
        n_vec++;
        if (overrun !== 1'b0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL ovr_one_cycle: got %h exp %h", obs, exp_v);
        end
        step(8'hF7, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b0);
        // re-fall on the same edge as the ack of code 4
        step(8'hEF, 1'b1, 1'b0);
        step(8'hEF, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        step(8'hEF, 1'b1, 1'b1);
        n_vec++;
        if (overrun !== 1'b0 || pending !== 8'h10 || {valid, A, B, C} !== 4'b1100 || obs !== exp_v) begin
            n_err++;
            $display("FAIL ovr_same_edge: got %h exp %h", obs, exp_v);
        end
        step(8'hEF, 1'b1, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || pending !== 8'h00 || obs !== exp_v) begin
            n_err++;
            $display("FAIL ovr_drain: got %h exp %h", obs, exp_v);
        end
        step(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_enable();
        step(8'hFE, 1'b1, 1'b0);
        step(8'hEE, 1'b0, 1'b0);
        n_vec++;
        if (pending !== 8'h01 || {valid, A, B, C} !== 4'b1000 || obs !== exp_v) begin
            n_err++;
            $display("FAIL en_gate: got %h exp %h", obs, exp_v);
        end
        step(8'hEE, 1'b0, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || pending !== 8'h00 || obs !== exp_v) begin
            n_err++;
            $display("FAIL en_drain: got %h exp %h", obs, exp_v);
        end
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        n_vec++;
        if (obs !== 13'h0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL en_quiet: got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        logic [7:0] y;
        y = 8'hFF;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) y = y ^ (8'h01 << $urandom_range(0, 7));
            step(y, ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0));
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rand_c%0d: got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_overrun();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
